// File: rtl/ysyx_24080006_mdu_ctrl_pkg.sv
// Shared types for the MDU issue front end: operation encodings, the
// operation-select struct handed to the MDU, controller states, and the
// RV32M funct3 decode.
package ysyx_24080006_mdu_ctrl_pkg;

   // Operation class understood by the iterative MDU.
   typedef enum logic [1:0] {
      ALU_MULL = 2'd0,
      ALU_MULH = 2'd1,
      ALU_DIV  = 2'd2,
      ALU_REM  = 2'd3
   } mdu_op_e;

   // Operation select presented to the MDU: op class plus operand signedness.
   typedef struct packed {
      mdu_op_e mdu_op;
      logic    signed_a;
      logic    signed_b;
   } mdu_set_t;

   // RV32M funct3 field of the OP/M-extension instructions.
   typedef enum logic [2:0] {
      F3_MUL    = 3'b000,
      F3_MULH   = 3'b001,
      F3_MULHSU = 3'b010,
      F3_MULHU  = 3'b011,
      F3_DIV    = 3'b100,
      F3_DIVU   = 3'b101,
      F3_REM    = 3'b110,
      F3_REMU   = 3'b111
   } mdu_funct3_e;

   // Controller states.
   //   IDLE  : no op in flight, ready for a new one
   //   BUSY  : MDU running an op whose result will be delivered
   //   DRAIN : op was flushed; MDU is left to finish, result is dropped
   //   HOLD  : result captured, waiting for the downstream handshake
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HOLD  = 2'd3
   } mdu_state_e;

   // Value of the operation select while nothing has been issued.
   localparam mdu_set_t MDU_SET_RESET = '{mdu_op: ALU_MULL, signed_a: 1'b0, signed_b: 1'b0};

   // Pure funct3 -> operation select decode. All eight encodings are legal.
   function automatic mdu_set_t mdu_decode(input logic [2:0] funct3);
      mdu_set_t s;
      s = MDU_SET_RESET;
      case (mdu_funct3_e'(funct3))
         F3_MUL:    s = '{mdu_op: ALU_MULL, signed_a: 1'b1, signed_b: 1'b1};
         F3_MULH:   s = '{mdu_op: ALU_MULH, signed_a: 1'b1, signed_b: 1'b1};
         F3_MULHSU: s = '{mdu_op: ALU_MULH, signed_a: 1'b1, signed_b: 1'b0};
         F3_MULHU:  s = '{mdu_op: ALU_MULH, signed_a: 1'b0, signed_b: 1'b0};
         F3_DIV:    s = '{mdu_op: ALU_DIV,  signed_a: 1'b1, signed_b: 1'b1};
         F3_DIVU:   s = '{mdu_op: ALU_DIV,  signed_a: 1'b0, signed_b: 1'b0};
         F3_REM:    s = '{mdu_op: ALU_REM,  signed_a: 1'b1, signed_b: 1'b1};
         F3_REMU:   s = '{mdu_op: ALU_REM,  signed_a: 1'b0, signed_b: 1'b0};
         default:   s = MDU_SET_RESET;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/ysyx_24080006_mdu_ctrl.sv
// EX-stage issue/sequencing front end for the iterative MDU. Latches an
// RV32M op, holds operands and mdu_valid stable for the whole MDU run,
// captures the single-cycle result and offers it downstream. A flush never
// aborts the MDU mid-operation: the op is drained and its result dropped.
//
// Handshake semantics (both sides): a transfer happens on a rising clock edge
// where valid and ready are both high. in_ready/out_valid depend only on the
// registered state plus flush/out_ready/reset; valid never waits for ready.
module ysyx_24080006_mdu_ctrl
   import ysyx_24080006_mdu_ctrl_pkg::*;
#(
   parameter int PERF_EN = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_funct3,
   input  logic [31:0] in_rs1,
   input  logic [31:0] in_rs2,
   input  logic [4:0]  in_rd,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [4:0]  out_rd,
   output logic [31:0] mdu_a,
   output logic [31:0] mdu_b,
   output mdu_set_t    mdu_set,
   output logic        mdu_valid,
   input  logic        mdu_ready,
   input  logic [31:0] mdu_o,
   output logic [31:0] perf_ops
);

   // Current/next controller state; state_q is the observable FSM state.
   mdu_state_e state_q;
   mdu_state_e state_d;

   logic       accept;    // new op transferred this cycle
   logic       capture;   // MDU result is kept for delivery
   logic       complete;  // result transferred downstream
   logic [4:0] rd_q;      // tag of the op currently in the MDU

   // Upstream ready: only from IDLE, or from HOLD when the held result leaves
   // this same cycle. Forced low while reset or flush is asserted.
   assign in_ready = !reset && !flush &&
                     ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready));
   assign accept   = in_valid && in_ready;

   // mdu_valid is a pure state decode so the MDU request never follows in_valid
   // combinationally; it stays high through DRAIN so the MDU keeps stepping.
   assign mdu_valid = (state_q == ST_BUSY) || (state_q == ST_DRAIN);
   assign out_valid = (state_q == ST_HOLD);

   assign capture  = (state_q == ST_BUSY) && mdu_ready && !flush;
   assign complete = (state_q == ST_HOLD) && out_ready && !flush;

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (mdu_ready) begin
               // A flush coinciding with the finish cycle simply discards the result.
               state_d = flush ? ST_IDLE : ST_HOLD;
            end else if (flush) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // Further flushes have nothing to squash; just wait for the finish.
            if (mdu_ready) begin
               state_d = ST_IDLE;
            end
         end
         ST_HOLD: begin
            if (flush) begin
               state_d = ST_IDLE;
            end else if (out_ready) begin
               state_d = accept ? ST_BUSY : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Operand/op-select/tag latch; written only on accept so they stay frozen
   // for the whole MDU run, including a drain.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mdu_a   <= 32'd0;
         mdu_b   <= 32'd0;
         mdu_set <= MDU_SET_RESET;
         rd_q    <= 5'd0;
      end else if (accept) begin
         mdu_a   <= in_rs1;
         mdu_b   <= in_rs2;
         mdu_set <= mdu_decode(in_funct3);
         rd_q    <= in_rd;
      end
   end

   // Result register: mdu_o is only valid during the finish cycle, so grab it
   // together with its tag; it then stays stable for the whole HOLD.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_data <= 32'd0;
         out_rd   <= 5'd0;
      end else if (capture) begin
         out_data <= mdu_o;
         out_rd   <= rd_q;
      end
   end

   // Completed-op counter (wraps), or constant zero when disabled.
   generate
      if (PERF_EN != 0) begin : g_perf
         logic [31:0] perf_q;

         // Count each delivered, non-flushed result.
         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               perf_q <= 32'd0;
            end else if (complete) begin
               perf_q <= perf_q + 32'd1;
            end
         end

         assign perf_ops = perf_q;
      end else begin : g_no_perf
         assign perf_ops = 32'd0;
      end
   endgenerate

endmodule

// File: tb/tb_ysyx_24080006_mdu_ctrl.sv
// Bench for the MDU issue front end. A behavioural MDU with a fixed latency
// answers requests; directed ops with hand-computed results are pushed into an
// expected queue on accept and a monitor compares every delivered result.
module tb_ysyx_24080006_mdu_ctrl;
   import ysyx_24080006_mdu_ctrl_pkg::*;

   localparam int MDU_LAT = 3;

   // ---------------- clock / reset / DUT signals ----------------
   logic        clk;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_funct3;
   logic [31:0] in_rs1;
   logic [31:0] in_rs2;
   logic [4:0]  in_rd;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [4:0]  out_rd;
   logic [31:0] mdu_a;
   logic [31:0] mdu_b;
   mdu_set_t    mdu_set;
   logic        mdu_valid;
   logic        mdu_ready;
   logic [31:0] mdu_o;
   logic [31:0] perf_ops;

   int checks;
   int failures;
   int ops_issued;
   int m_starts;

   logic [36:0] exp_q[$];   // {rd, data}

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   ysyx_24080006_mdu_ctrl #(.PERF_EN(1)) dut (
      .clock     (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_funct3 (in_funct3),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .in_rd     (in_rd),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_rd    (out_rd),
      .mdu_a     (mdu_a),
      .mdu_b     (mdu_b),
      .mdu_set   (mdu_set),
      .mdu_valid (mdu_valid),
      .mdu_ready (mdu_ready),
      .mdu_o     (mdu_o),
      .perf_ops  (perf_ops)
   );

   // ---------------- behavioural MDU ----------------
   function automatic logic [31:0] mdu_model(input logic [31:0] a, input logic [31:0] b,
                                             input mdu_set_t s);
      logic signed [65:0] ea;
      logic signed [65:0] eb;
      logic signed [65:0] p;
      logic [31:0] r;
      logic ovf;
      ea  = s.signed_a ? {{34{a[31]}}, a} : {34'd0, a};
      eb  = s.signed_b ? {{34{b[31]}}, b} : {34'd0, b};
      p   = ea * eb;
      ovf = s.signed_a && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      r   = 32'd0;
      case (s.mdu_op)
         ALU_MULL: r = a * b;
         ALU_MULH: r = p[63:32];
         ALU_DIV: begin
            if (b == 32'd0)      r = 32'hFFFF_FFFF;
            else if (ovf)        r = 32'h8000_0000;
            else if (s.signed_a) r = $signed(a) / $signed(b);
            else                 r = a / b;
         end
         ALU_REM: begin
            if (b == 32'd0)      r = a;
            else if (ovf)        r = 32'd0;
            else if (s.signed_a) r = $signed(a) % $signed(b);
            else                 r = a % b;
         end
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   logic       m_busy;
   logic [3:0] m_cnt;

   initial m_starts = 0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_busy <= 1'b0;
         m_cnt  <= 4'd0;
      end else if (!m_busy) begin
         if (mdu_valid) begin
            m_busy   <= 1'b1;
            m_cnt    <= 4'(MDU_LAT);
            m_starts <= m_starts + 1;
         end
      end else if (m_cnt == 4'd0) begin
         m_busy <= 1'b0;
      end else begin
         m_cnt <= m_cnt - 4'd1;
      end
   end

   assign mdu_ready = m_busy && (m_cnt == 4'd0);
   assign mdu_o     = mdu_ready ? mdu_model(mdu_a, mdu_b, mdu_set) : 32'hDEAD_BEEF;

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      logic [36:0] e;
      if (!reset && out_valid && out_ready && !flush) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out: got data %h rd %0d expected no result", out_data, out_rd);
         end else begin
            e = exp_q.pop_front();
            check("out_data", out_data, e[31:0]);
            check("out_rd", 32'(out_rd), 32'(e[36:32]));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Present an op and hold it until accepted; returns in the cycle after accept.
   task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input bit do_exp);
      bit done;
      done      = 1'b0;
      in_valid  = 1'b1;
      in_funct3 = f3;
      in_rs1    = a;
      in_rs2    = b;
      in_rd     = rd;
      for (int n = 0; n < 100 && !done; n++) begin
         #1;
         if (in_ready) begin
            if (do_exp) exp_q.push_back({rd, exp});
            ops_issued++;
            done = 1'b1;
         end
         step();
      end
      in_valid = 1'b0;
      if (!done) check("issue_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_empty();
      bit done;
      done = 1'b0;
      for (int n = 0; n < 60 && !done; n++) begin
         if (exp_q.size() == 0 && !out_valid && !mdu_valid) done = 1'b1;
         else step();
      end
      if (!done) check("drain_timeout", 32'(exp_q.size()), 32'd0);
   endtask

   // ---------------- directed vectors ----------------
   localparam int NV = 10;
   logic [2:0]  v_f3  [NV] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b100,
                               3'b110, 3'b111, 3'b101, 3'b110, 3'b100};
   logic [31:0] v_a   [NV] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000,
                               32'h8000_0000, 32'd7, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
   logic [31:0] v_b   [NV] = '{32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF,
                               32'hFFFF_FFFF, 32'd0, 32'd7, 32'd2, 32'd2};
   logic [31:0] v_exp [NV] = '{32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h8000_0000,
                               32'h0000_0000, 32'd7, 32'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFD};

   // ---------------- main sequence ----------------
   initial begin
      bit seen;
      bit mv_ok;
      bit ir_bad;
      bit ov_bad;
      bit hold_bad;

      checks     = 0;
      failures   = 0;
      ops_issued = 0;
      reset      = 1'b1;
      flush      = 1'b0;
      in_valid   = 1'b0;
      in_funct3  = 3'd0;
      in_rs1     = 32'd0;
      in_rs2     = 32'd0;
      in_rd      = 5'd0;
      out_ready  = 1'b1;

      // Reset values, before any clock edge.
      #3;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_mdu_valid", 32'(mdu_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_mdu_a", mdu_a, 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_mdu_set", 32'(mdu_set), 32'(MDU_SET_RESET));
      check("rst_perf", perf_ops, 32'd0);
      step();
      step();
      reset = 1'b0;
      #1;
      check("idle_in_ready", 32'(in_ready), 32'd1);
      step();

      // MUL 7 x -3 with latency check: out_valid the cycle after mdu_ready.
      issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, 1'b1);
      check("mul_mdu_set", 32'(mdu_set), 32'({ALU_MULL, 1'b1, 1'b1}));
      check("mul_mdu_valid", 32'(mdu_valid), 32'd1);
      seen = 1'b0;
      for (int n = 0; n < 40 && !seen; n++) begin
         if (mdu_ready) seen = 1'b1;
         else step();
      end
      check("mul_mdu_ready_seen", 32'(seen), 32'd1);
      check("mul_out_valid_early", 32'(out_valid), 32'd0);
      step();
      check("mul_out_valid_next", 32'(out_valid), 32'd1);
      wait_empty();

      // All funct3 encodings, division corner cases.
      for (int i = 0; i < NV; i++) begin
         issue(v_f3[i], v_a[i], v_b[i], 5'(i + 10), v_exp[i], 1'b1);
         wait_empty();
      end
      check("perf_after_directed", perf_ops, 32'd11);

      // Flush three cycles after accept: op drains, no output.
      issue(3'b101, 32'd100, 32'd7, 5'd9, 32'd0, 1'b0);
      step();
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      seen   = 1'b0;
      mv_ok  = 1'b1;
      ir_bad = 1'b0;
      ov_bad = 1'b0;
      for (int n = 0; n < 40 && !seen; n++) begin
         mv_ok  = mv_ok & mdu_valid;
         ir_bad = ir_bad | in_ready;
         ov_bad = ov_bad | out_valid;
         if (mdu_ready) seen = 1'b1;
         else step();
      end
      check("drain_finish_seen", 32'(seen), 32'd1);
      check("drain_mdu_valid_high", 32'(mv_ok), 32'd1);
      check("drain_in_ready_low", 32'(ir_bad), 32'd0);
      step();
      check("drain_in_ready_after", 32'(in_ready), 32'd1);
      check("drain_mdu_valid_after", 32'(mdu_valid), 32'd0);
      check("drain_no_out_valid", 32'(ov_bad | out_valid), 32'd0);
      check("drain_perf", perf_ops, 32'd11);

      // Back-to-back: DIVU 100/7 held 5 cycles, then MUL 3x4 on the release cycle.
      out_ready = 1'b0;
      issue(3'b101, 32'd100, 32'd7, 5'd5, 32'd14, 1'b1);
      seen = 1'b0;
      for (int n = 0; n < 40 && !seen; n++) begin
         if (out_valid) seen = 1'b1;
         else step();
      end
      check("b2b_out_valid_seen", 32'(seen), 32'd1);
      in_valid  = 1'b1;
      in_funct3 = 3'b000;
      in_rs1    = 32'd3;
      in_rs2    = 32'd4;
      in_rd     = 5'd6;
      hold_bad  = 1'b0;
      ir_bad    = 1'b0;
      for (int n = 0; n < 5; n++) begin
         #1;
         hold_bad = hold_bad | !out_valid | (out_data != 32'd14) | (out_rd != 5'd5);
         ir_bad   = ir_bad | in_ready;
         step();
      end
      check("b2b_hold_stable", 32'(hold_bad), 32'd0);
      check("b2b_in_ready_held", 32'(ir_bad), 32'd0);
      out_ready = 1'b1;
      #1;
      check("b2b_same_cycle_accept", 32'(in_ready), 32'd1);
      exp_q.push_back({5'd6, 32'd12});
      ops_issued++;
      step();
      in_valid = 1'b0;
      check("b2b_second_mdu_a", mdu_a, 32'd3);
      check("b2b_second_busy", 32'(mdu_valid), 32'd1);
      wait_empty();
      check("b2b_perf", perf_ops, 32'd13);

      // Asynchronous reset while BUSY: outputs clear without a clock edge.
      issue(3'b000, 32'd5, 32'd6, 5'd7, 32'd0, 1'b0);
      step();
      check("areset_pre_busy", 32'(mdu_valid), 32'd1);
      reset = 1'b1;
      #1;
      check("areset_mdu_valid", 32'(mdu_valid), 32'd0);
      check("areset_in_ready", 32'(in_ready), 32'd0);
      check("areset_out_valid", 32'(out_valid), 32'd0);
      check("areset_mdu_a", mdu_a, 32'd0);
      check("areset_mdu_b", mdu_b, 32'd0);
      check("areset_mdu_set", 32'(mdu_set), 32'(MDU_SET_RESET));
      check("areset_out_data", out_data, 32'd0);
      check("areset_out_rd", 32'(out_rd), 32'd0);
      check("areset_perf", perf_ops, 32'd0);
      step();
      reset = 1'b0;
      step();
      check("post_reset_in_ready", 32'(in_ready), 32'd1);

      // The MDU must have started exactly once per issued op.
      check("mdu_start_count", 32'(m_starts), 32'(ops_issued));
      check("exp_q_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
